regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 8 x 16-bit register bank (`register_access`). It shares the bank's single write port between two requesters, the ALU result path and the memory-load path. Requests use a valid/ready handshake and are granted round-robin. Each granted request becomes exactly one registered, one-cycle, one-hot `reg_en` pulse with matching `wb_data`. The block sits between the execute/load stages and the register bank, and drives `register_access`'s `reg_en` and `ALU_result` inputs directly.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_onehot_decoder.sv | 18 +
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-bank write-back path.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  // Write-back source encoding, also used as the round-robin pointer value.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  // One write request: destination register and payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_onehot_decoder.sv
// Register-index to one-hot write strobe decoder with enable.
module onehot_decoder
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot_c
);

  // All-zero when disabled, otherwise exactly one bit set.
  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// the ALU result path and the memory-load path, with one registered stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [DATA_W-1:0]   wb_data,
  output logic                wb_src,
  output logic                conflict
);

  wb_req_t             alu_req;
  wb_req_t             mem_req;
  wb_req_t             win_req;
  wb_src_e             win_src;
  wb_src_e             last_grant;
  logic                grant;
  logic                conflict_c;
  logic [NUM_REGS-1:0] dec_onehot;

  assign alu_req = {alu_addr, alu_data};
  assign mem_req = {mem_addr, mem_data};

  // Grant decision: single requester wins outright, contention goes to the
  // source not granted last; nothing is accepted during stall or reset.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    win_src   = SRC_ALU;
    win_req   = alu_req;
    if (!rst && !stall) begin
      if (alu_valid && mem_valid) begin
        if (last_grant == SRC_MEM) begin
          alu_ready = 1'b1;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
    if (mem_ready) begin
      win_src = SRC_MEM;
      win_req = mem_req;
    end
  end

  assign grant      = alu_ready | mem_ready;
  assign conflict_c = !rst && !stall && alu_valid && mem_valid && (alu_addr == mem_addr);

  onehot_decoder u_dec (
    .en       (grant),
    .addr     (win_req.addr),
    .onehot_c (dec_onehot)
  );

  // Write-stage register and priority pointer; reset kills any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_en     <= '0;
      wb_data    <= '0;
      wb_src     <= 1'b0;
      conflict   <= 1'b0;
      last_grant <= SRC_MEM;
    end else begin
      reg_en   <= dec_onehot;
      conflict <= conflict_c;
      if (grant) begin
        wb_data    <= win_req.data;
        wb_src     <= 1'(win_src);
        last_grant <= win_src;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a driver predicts grants from the
// arbitration rules and queues expected writes; a monitor checks every pulse.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                stall;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_ready;
  logic [NUM_REGS-1:0] reg_en;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_src;
  logic                conflict;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .reg_en    (reg_en),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    int addr;
    int data;
    int src;
    int confl;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   m_last      = 1;  // reference: source granted most recently (1 = MEM)
  bit   alu_acc;
  bit   mem_acc;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge, match a write pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_en != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(reg_en), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_latency", 32'(cyc), 32'(e.stamp + 1));
          chk("reg_en",     32'(reg_en), 32'd1 << e.addr);
          chk("wb_data",    32'(wb_data), 32'(e.data));
          chk("wb_src",     32'(wb_src), 32'(e.src));
          chk("conflict",   32'(conflict), 32'(e.confl));
        end
      end else begin
        if (sb.size() > 0 && sb[0].stamp == cyc - 1) begin
          e = sb.pop_front();
          chk("missing_write", 32'(reg_en), 32'd1 << e.addr);
        end else begin
          chk("idle_conflict", 32'(conflict), 32'd0);
        end
      end
    end
  end

  // One clock of stimulus: predict readies from the rules, queue the write.
  task automatic cycle();
    exp_t e;
    bit   ea;
    bit   em;
    @(negedge clk);
    ea = 1'b0;
    em = 1'b0;
    if (!rst && !stall) begin
      if (alu_valid && mem_valid) begin
        if (m_last == 1) ea = 1'b1;
        else             em = 1'b1;
      end else begin
        ea = alu_valid;
        em = mem_valid;
      end
    end
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    chk("mem_ready", 32'(mem_ready), 32'(em));
    if (ea || em) begin
      e.stamp = cyc;
      e.addr  = em ? int'(mem_addr) : int'(alu_addr);
      e.data  = em ? int'(mem_data) : int'(alu_data);
      e.src   = em ? 1 : 0;
      e.confl = (alu_valid && mem_valid && alu_addr == mem_addr) ? 1 : 0;
      sb.push_back(e);
      m_last = e.src;
    end
    alu_acc = ea;
    mem_acc = em;
    @(posedge clk);
    #1;
    if (alu_acc) alu_valid = 1'b0;
    if (mem_acc) mem_valid = 1'b0;
  endtask

  task automatic req_alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic req_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_data  = d;
  endtask

  // Run until both requesters are served, then let the last pulse drain.
  task automatic drain();
    int n = 0;
    while ((alu_valid || mem_valid) && n < 20) begin
      cycle();
      n++;
    end
    if (alu_valid || mem_valid) chk("drain_timeout", {30'd0, alu_valid, mem_valid}, 32'd0);
    repeat (2) cycle();
  endtask

  initial begin
    // Reset held 3 cycles with both requesters valid (contention values).
    rst   = 1'b1;
    stall = 1'b0;
    req_alu(3'd0, 16'h0003);
    req_mem(3'd7, 16'hC000);
    repeat (3) cycle();
    chk("rst_reg_en",   32'(reg_en), 32'd0);
    chk("rst_wb_data",  32'(wb_data), 32'd0);
    chk("rst_wb_src",   32'(wb_src), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    rst = 1'b0;
    drain();

    // Same-address conflict: ALU first, then MEM overwrites.
    req_alu(3'd5, 16'h0C00);
    req_mem(3'd5, 16'h1111);
    drain();

    // Single ALU write.
    req_alu(3'd2, 16'h0030);
    drain();

    // Stall rising with valid, held 4 cycles, then accepts resume.
    stall = 1'b1;
    req_alu(3'd4, 16'hBEEF);
    repeat (4) cycle();
    stall = 1'b0;
    drain();

    // Reset during a live pulse: pulse dies at once, pointer back to MEM.
    req_alu(3'd1, 16'h1234);
    req_mem(3'd6, 16'h5678);
    cycle();
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_reg_en", 32'(reg_en), 32'd0);
    sb.delete();
    m_last = 1;
    req_alu(3'd1, 16'h1234);
    repeat (2) cycle();
    rst = 1'b0;
    drain();

    // Randomized traffic with stalls and frequent address collisions.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      if (!alu_valid && $urandom_range(0, 3) != 0)
        req_alu(3'($urandom_range(0, 7)), 16'($urandom));
      if (!mem_valid && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0) req_mem(alu_addr, 16'($urandom));
        else                           req_mem(3'($urandom_range(0, 7)), 16'($urandom));
      end
      cycle();
    end
    stall = 1'b0;
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
